// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic units.
// FSM state encodings and the default operand width.
package serial_subtractor_pkg;

  localparam int SUB_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: x - y - bin.
// Produces the difference bit and the outgoing borrow.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic w_xy;

  // Difference and borrow for a single bit position
  always_comb begin
    w_xy = x ^ y;
    d    = w_xy ^ bin;
    bout = (~x & y) | (~w_xy & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// start/busy/done framing; results held until the next completion.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res_sr;
  logic             r_bor;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_zero;

  logic             w_d;
  logic             w_bor_nxt;
  logic [WIDTH-1:0] w_res_nxt;
  logic             w_last;

  full_subtractor u_fs (
    .x    (r_a_sr[0]),
    .y    (r_b_sr[0]),
    .bin  (r_bor),
    .d    (w_d),
    .bout (w_bor_nxt)
  );

  // Next result word and final-bit detect
  always_comb begin
    w_res_nxt = {w_d, r_res_sr[WIDTH-1:1]};
    w_last    = (r_cnt == LAST);
  end

  // Control FSM, shift datapath and registered result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_bor    <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a_sr   <= a_in;
            r_b_sr   <= b_in;
            r_res_sr <= '0;
            r_bor    <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_res_sr <= w_res_nxt;
          r_bor    <= w_bor_nxt;
          if (w_last) begin
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_diff   <= w_res_nxt;
            r_borrow <= w_bor_nxt;
            r_zero   <= (w_res_nxt == '0);
            r_state  <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign diff       = r_diff;
  assign borrow_out = r_borrow;
  assign zero       = r_zero;

endmodule
